nanocpu_dmem: RTL
=================

# nanocpu_dmem

Data-memory responder for the nanoCPU data port. It answers the CPU's `d_address` / `d_data` / `mem_wr` bus with a word-addressed RAM and a small memory-mapped I/O block: LED register, synchronized switch input, free-running cycle counter and a compare timer with an interrupt flag. Reads are combinational, so a load completes in the same cycle. Writes commit on the rising clock edge.

## Interface
- `ADDR_W`, 8: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `d_address`  in  32  byte address from the CPU ALU result.
- `d_data`  inout  32  bidirectional data.
  - Driven by this block only when `mem_wr`=0.
  - High-Z when `mem_wr`=1, because the CPU drives it.
- `mem_wr`  in  1  write strobe from the CPU, 1 = store.
- `sw`  in  16  asynchronous switch inputs.
- `led`  out  16  LED register output.
- `timer_irq`  out  1  timer match flag, level.

## Operation
- **Address decode**
  - `d_address[1:0]` is ignored, so all accesses are whole words.
  - `d_address[31]`=0 selects RAM, word index `d_address[ADDR_W+1:2]`. Higher bits alias.
  - `d_address[31]`=1 selects I/O by `d_address[4:2]`. Bits [30:5] are ignored.
- **RAM**
  - Read: `d_data` = mem[index], combinational.
  - Write: mem[index] <= `d_data` on the clock edge when `mem_wr`=1.
  - Contents are not cleared by reset. Writes are suppressed while `reset`=1.
- **I/O map** (offset = `d_address[4:2]`)
  - 0 LED, RW. Bits [15:0] are stored and drive `led`. Upper bits read 0.
  - 1 SW, RO. Reads `sw` after a two-flop synchronizer, zero-extended.
  - 2 CYCLE, RO. 32-bit counter that increments every cycle and wraps 0xFFFFFFFF -> 0.
  - 3 TCMP, RW. 32-bit compare value.
  - 4 TCTRL. Bit0 `en` (RW), bit1 `flag` (RO, write 1 to clear), bit2 `reload` (RW). Other bits read 0.
  - 5 TCNT, RW. 32-bit timer count.
  - 6, 7: read 0, writes ignored.
- **Writes to RO registers**: writes to SW and CYCLE are ignored.
- **Timer**, evaluated each cycle while `en`=1:
  - If TCNT == TCMP: `flag` <= 1.
    - If `reload`=1: TCNT <= 0.
    - If `reload`=0: TCNT holds and `en` <= 0 (one-shot).
  - Otherwise TCNT <= TCNT+1, wrapping.
- **Timer with `en`=0**: TCNT holds.
- **`timer_irq`** = `flag`.
- **Simultaneous events**
  - A CPU write to TCNT or TCMP in a cycle takes priority over the timer update to TCNT in that cycle. The match check uses the pre-write values.
  - A hardware `flag` set wins over a write-1-clear in the same cycle.
  - A TCTRL write sets `en`/`reload` from the write data. The write's `flag` handling follows the rule above.

## Timing
- Read latency is 0 cycles. `d_data` is valid combinationally from `d_address` whenever `mem_wr`=0.
- Write takes effect at the next rising edge. A read of the same address in the following cycle returns the new value.
- SW read reflects the `sw` pins after 2 edges.
- **Timer match timing**: a match is detected on the edge where TCNT == TCMP. `flag` and `timer_irq` are high from that edge.
  - Example: TCMP=N, TCNT=0, `en` written 1 at edge 0. `flag` rises at edge N+1.
- **Reset values** (asserted immediately on `reset`, independent of `clock`):
  - `led`=0, synchronizer=0, CYCLE=0, TCMP=0, TCNT=0, `en`=0, `reload`=0, `flag`=0, `timer_irq`=0.
  - `d_data` follows the decode, with RAM contents unknown.
- **Reset mid-operation**: a reset asserted mid-count stops the timer and clears `flag` at once. Counting resumes only after software re-enables it.

## Test plan
- **RAM store/load**: store 0xDEADBEEF to 0x00000010, then load 0x00000010 -> `d_data`=0xDEADBEEF.
  - Load 0x00000410 with `ADDR_W`=8 -> same value (alias).
  - While `mem_wr`=1, `d_data` is not driven by the block.
- **LED and SW**
  - Store 0x1234ABCD to 0x80000000 -> `led`=0xABCD; read back 0x0000ABCD.
  - Set `sw`=0x00F0 -> SW read returns 0x000000F0 by the second edge.
- **CYCLE counter**: release reset, read CYCLE twice 5 cycles apart -> difference is 5.
  - Force wrap from 0xFFFFFFFF -> reads 0 next cycle.
- **One-shot timer**: TCMP=3, TCNT=0, TCTRL=0x1 -> `timer_irq` rises 4 edges after the enable write.
  - TCNT stays 3, `en` reads 0.
  - Writing TCTRL=0x2 clears `timer_irq`.
- **Auto-reload timer**: TCMP=2, TCTRL=0x5 -> `timer_irq` set and TCNT sequence 1,2,0,1,2,0.
  - A write-1-clear coinciding with a match leaves `flag`=1.
- **Async reset mid-operation**: assert `reset` between edges during a running timer with `led`=0xFFFF.
  - `led`, `timer_irq` and TCNT go to 0 before the next edge.
  - A RAM word written before reset is still readable after reset.

Source files
------------

// File: rtl/nanocpu_dmem_if.sv
// nanocpu_dmem_if: CPU data-port request signals (byte address and store strobe).
// The bidirectional data bus stays a plain inout on the responder so that
// tristate resolution happens on an ordinary net.
interface nanocpu_dmem_if;
    logic [31:0] d_address;
    logic        mem_wr;

    modport master (output d_address, output mem_wr);
    modport slave  (input  d_address, input  mem_wr);
endinterface

// File: rtl/nanocpu_dmem.sv
// nanocpu_dmem: data-memory responder for the nanoCPU data port.
// Word-addressed RAM below 0x80000000, memory-mapped I/O above it.
// I/O block: LED register, synchronized switches, free-running cycle counter,
// and a compare timer with a sticky match flag that drives timer_irq.
// Loads are combinational. Stores commit on the rising clock edge.
module nanocpu_dmem #(
    parameter int ADDR_W = 8
) (
    input  logic          clock,
    input  logic          reset,
    nanocpu_dmem_if.slave bus,
    inout  wire  [31:0]   d_data,
    input  logic [15:0]   sw,
    output logic [15:0]   led,
    output logic          timer_irq
);
    localparam logic [2:0] OFS_LED   = 3'd0;
    localparam logic [2:0] OFS_SW    = 3'd1;
    localparam logic [2:0] OFS_CYCLE = 3'd2;
    localparam logic [2:0] OFS_TCMP  = 3'd3;
    localparam logic [2:0] OFS_TCTRL = 3'd4;
    localparam logic [2:0] OFS_TCNT  = 3'd5;

    // RAM storage, deliberately not reset
    logic [31:0] mem_q [0:(1 << ADDR_W) - 1];

    logic [ADDR_W-1:0] ram_idx_s;
    logic              io_sel_s;
    logic [2:0]        io_ofs_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rdata_s;
    logic              unused_addr_s;

    logic              wr_ram_s;
    logic              wr_led_s;
    logic              wr_tcmp_s;
    logic              wr_tctrl_s;
    logic              wr_tcnt_s;
    logic              match_s;

    logic [15:0]       led_q,      led_d;
    logic [15:0]       sw_meta_q;
    logic [15:0]       sw_sync_q;
    logic [31:0]       cycle_q;
    logic [31:0]       tcmp_q,     tcmp_d;
    logic [31:0]       tcnt_q,     tcnt_d;
    logic              en_q,       en_d;
    logic              reload_q,   reload_d;
    logic              flag_q,     flag_d;

    assign io_sel_s  = bus.d_address[31];
    assign io_ofs_s  = bus.d_address[4:2];
    assign ram_idx_s = bus.d_address[ADDR_W+1:2];
    // Byte-lane bits, aliasing RAM bits and I/O bits [30:5] play no part in decode
    assign unused_addr_s = &{1'b0, bus.d_address};

    // While the CPU stores it owns the bus; otherwise we drive the read data
    assign d_data  = bus.mem_wr ? 32'hzzzz_zzzz : rdata_s;
    assign wdata_s = d_data;

    assign match_s   = en_q && (tcnt_q == tcmp_q);
    assign led       = led_q;
    assign timer_irq = flag_q;

    // Store decode: one strobe per writable target, none while reset is held
    always_comb begin
        wr_ram_s   = 1'b0;
        wr_led_s   = 1'b0;
        wr_tcmp_s  = 1'b0;
        wr_tctrl_s = 1'b0;
        wr_tcnt_s  = 1'b0;
        if (bus.mem_wr && !reset) begin
            if (!io_sel_s) begin
                wr_ram_s = 1'b1;
            end else begin
                case (io_ofs_s)
                    OFS_LED:   wr_led_s   = 1'b1;
                    OFS_TCMP:  wr_tcmp_s  = 1'b1;
                    OFS_TCTRL: wr_tctrl_s = 1'b1;
                    OFS_TCNT:  wr_tcnt_s  = 1'b1;
                    default:   wr_ram_s   = 1'b0;
                endcase
            end
        end else begin
            wr_ram_s = 1'b0;
        end
    end

    // Load mux: RAM word or I/O register, zero-extended where narrower
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!io_sel_s) begin
            rdata_s = mem_q[ram_idx_s];
        end else begin
            case (io_ofs_s)
                OFS_LED:   rdata_s = {16'h0000, led_q};
                OFS_SW:    rdata_s = {16'h0000, sw_sync_q};
                OFS_CYCLE: rdata_s = cycle_q;
                OFS_TCMP:  rdata_s = tcmp_q;
                OFS_TCTRL: rdata_s = {29'h0000_0000, reload_q, flag_q, en_q};
                OFS_TCNT:  rdata_s = tcnt_q;
                default:   rdata_s = 32'h0000_0000;
            endcase
        end
    end

    // Next state for LED and timer; CPU writes override the timer's own update
    always_comb begin
        led_d    = led_q;
        tcmp_d   = tcmp_q;
        tcnt_d   = tcnt_q;
        en_d     = en_q;
        reload_d = reload_q;
        flag_d   = flag_q;

        if (wr_led_s) begin
            led_d = wdata_s[15:0];
        end else begin
            led_d = led_q;
        end

        if (wr_tcmp_s) begin
            tcmp_d = wdata_s;
        end else begin
            tcmp_d = tcmp_q;
        end

        if (wr_tcnt_s) begin
            tcnt_d = wdata_s;
        end else if (en_q && !match_s) begin
            tcnt_d = tcnt_q + 32'd1;
        end else if (match_s && reload_q) begin
            tcnt_d = 32'h0000_0000;
        end else begin
            tcnt_d = tcnt_q;
        end

        if (wr_tctrl_s) begin
            en_d     = wdata_s[0];
            reload_d = wdata_s[2];
        end else if (match_s && !reload_q) begin
            en_d     = 1'b0;
            reload_d = reload_q;
        end else begin
            en_d     = en_q;
            reload_d = reload_q;
        end

        // A hardware match beats a same-cycle write-1-to-clear
        if (match_s) begin
            flag_d = 1'b1;
        end else if (wr_tctrl_s && wdata_s[1]) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // RAM write port
    always_ff @(posedge clock) begin
        if (wr_ram_s) begin
            mem_q[ram_idx_s] <= wdata_s;
        end
    end

    // I/O registers, switch synchronizer and cycle counter with async reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q     <= 16'h0000;
            sw_meta_q <= 16'h0000;
            sw_sync_q <= 16'h0000;
            cycle_q   <= 32'h0000_0000;
            tcmp_q    <= 32'h0000_0000;
            tcnt_q    <= 32'h0000_0000;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_q + 32'd1;
            tcmp_q    <= tcmp_d;
            tcnt_q    <= tcnt_d;
            en_q      <= en_d;
            reload_q  <= reload_d;
            flag_q    <= flag_d;
        end
    end
endmodule
